// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM arbiter (reader > clear > host); reads return 2 cycles after request.
// Host writes are back-pressured via wr_ready whenever the reader or clear engine owns the RAM.
module fb_port_arbiter #(
   parameter int unsigned COLS   = 240,
   parameter int unsigned PAGES  = 8,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [7:0]        rd_x,
   input  logic [2:0]        rd_page,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_x,
   input  logic [2:0]        wr_page,
   input  logic [7:0]        wr_data,
   input  logic              clear_start,
   input  logic [7:0]        clear_value,
   output logic              busy,
   output logic              clear_done,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);
   localparam int unsigned FB_BYTES = COLS * PAGES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [7:0]        fill_q;
   logic              clear_done_q;
   logic              rd_p1_q;
   logic              rd_oor_p1_q;
   logic              rd_valid_q;
   logic [7:0]        rd_data_q;
   logic [7:0]        err_q;
   logic [7:0]        err_d;

   logic              rd_oor;
   logic              wr_oor;
   logic              wr_hs;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;

   assign rd_oor  = (32'(rd_x) >= COLS) || (32'(rd_page) >= PAGES);
   assign wr_oor  = (32'(wr_x) >= COLS) || (32'(wr_page) >= PAGES);
   assign rd_addr = ADDR_W'(32'(rd_x) * PAGES + 32'(rd_page));
   assign wr_addr = ADDR_W'(32'(wr_x) * PAGES + 32'(wr_page));

   assign busy       = (state_q == FILL);
   assign wr_ready   = reset & ~rd_req & ~busy;
   assign wr_hs      = wr_valid & wr_ready;
   assign clear_done = clear_done_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign err_count  = err_q;

   // Out-of-range host writes still complete the handshake but never reach the RAM.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (rd_req) begin
         mem_addr = rd_addr;
      end else if (busy) begin
         mem_addr  = cnt_q;
         mem_we    = 1'b1;
         mem_wdata = fill_q;
      end else if (wr_hs) begin
         mem_addr  = wr_addr;
         mem_we    = ~wr_oor;
         mem_wdata = wr_data;
      end
   end

   always_comb begin
      err_d = err_q;
      if (wr_hs && wr_oor && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   // Stage 1 tracks the request while the RAM fetches; stage 2 captures the byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_p1_q     <= 1'b0;
         rd_oor_p1_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_p1_q     <= rd_req;
         rd_oor_p1_q <= rd_oor;
         rd_valid_q  <= rd_p1_q;
         if (rd_p1_q) begin
            rd_data_q <= rd_oor_p1_q ? 8'h00 : mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fill_q       <= '0;
         clear_done_q <= 1'b0;
      end else begin
         clear_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear_start) begin
                  fill_q  <= clear_value;
                  cnt_q   <= '0;
                  state_q <= FILL;
               end
            end
            FILL: begin
               if (!rd_req) begin
                  if (cnt_q == LAST_ADDR) begin
                     cnt_q        <= '0;
                     clear_done_q <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + ADDR_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboarded bench for fb_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_port_arbiter;
   localparam int FB = 1920;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   logic [7:0]  rd_x;
   logic [2:0]  rd_page;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_x;
   logic [2:0]  wr_page;
   logic [7:0]  wr_data;
   logic        clear_start;
   logic [7:0]  clear_value;
   logic        busy;
   logic        clear_done;
   logic [7:0]  err_count;
   logic [10:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram    [0:2047];
   logic [7:0]  shadow [0:FB-1];

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } rd_exp_t;

   rd_exp_t rq[$];
   rd_exp_t mon_e;
   int      cyc = 0;
   int      n_chk = 0;
   int      n_fail = 0;

   fb_port_arbiter #(.COLS(240), .PAGES(8), .ADDR_W(11)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_x(rd_x), .rd_page(rd_page),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_page(wr_page), .wr_data(wr_data),
      .clear_start(clear_start), .clear_value(clear_value),
      .busy(busy), .clear_done(clear_done), .err_count(err_count),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         if (rq.size() == 0) begin
            check("rd_spurious", 1, 0);
         end else begin
            mon_e = rq.pop_front();
            check("rd_latency", cyc, mon_e.cyc);
            check("rd_data", {24'h0, rd_data}, {24'h0, mon_e.data});
         end
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
         check("rd_missing", 0, 1);
         mon_e = rq.pop_front();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_rd(input logic [7:0] x, input logic [2:0] pg);
      if (x >= 8'd240) return 8'h00;
      return shadow[int'(x) * 8 + int'(pg)];
   endfunction

   task automatic rd_push(input logic [7:0] x, input logic [2:0] pg, input logic [7:0] e);
      rd_exp_t t;
      rd_req  = 1'b1;
      rd_x    = x;
      rd_page = pg;
      t.data  = e;
      t.cyc   = cyc + 2;
      rq.push_back(t);
   endtask

   task automatic host_write(input logic [7:0] x, input logic [2:0] pg, input logic [7:0] d,
                             output int waits, output logic we, output logic [10:0] addr,
                             output logic [7:0] wd);
      wr_valid = 1'b1;
      wr_x     = x;
      wr_page  = pg;
      wr_data  = d;
      waits    = 0;
      #3;
      while (!wr_ready && waits < 100) begin
         step();
         #3;
         waits++;
      end
      if (!wr_ready) check("wr_timeout", 0, 1);
      we   = mem_we;
      addr = mem_addr;
      wd   = mem_wdata;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic run_fill(input logic [7:0] v, input bit restart_pulse,
                           output int busy_n, output int done_n, output int wr_n, output int bad_n);
      clear_start = 1'b1;
      clear_value = v;
      step();
      clear_start = 1'b0;
      clear_value = 8'h00;
      busy_n = 0; done_n = 0; wr_n = 0; bad_n = 0;
      for (int k = 0; k < 2000; k++) begin
         clear_start = restart_pulse && (k == 500);
         #3;
         if (busy) busy_n++;
         if (clear_done) done_n++;
         if (busy && wr_ready) bad_n++;
         if (mem_we) begin
            if (mem_addr != 11'(wr_n) || mem_wdata != v) bad_n++;
            wr_n++;
         end
         step();
      end
      clear_start = 1'b0;
      for (int a = 0; a < FB; a++) shadow[a] = v;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          waits, busy_n, done_n, wr_n, bad_n, cnt_m, nrd, a;
      logic        we;
      logic [10:0] addr;
      logic [7:0]  wd, x, e;
      logic [2:0]  pg;
      logic [7:0]  rx [4];
      logic [2:0]  rp [4];

      for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
      for (int i = 0; i < FB; i++) shadow[i] = 8'h00;
      reset = 1'b0; rd_req = 1'b0; rd_x = '0; rd_page = '0;
      wr_valid = 1'b1; wr_x = '0; wr_page = '0; wr_data = '0;
      clear_start = 1'b0; clear_value = '0;

      // Reset state
      step(); step();
      #3;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_clear_done", clear_done, 0);
      check("rst_err_count", err_count, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_wr_ready", wr_ready, 0);
      step();
      wr_valid = 1'b0;
      reset = 1'b1;
      step();

      // Basic host write then read-back
      host_write(8'd5, 3'd2, 8'hA5, waits, we, addr, wd);
      check("t1_wr_waits", waits, 0);
      check("t1_mem_we", we, 1);
      check("t1_mem_addr", addr, 42);
      check("t1_mem_wdata", wd, 8'hA5);
      shadow[42] = 8'hA5;
      rd_push(8'd5, 3'd2, exp_rd(8'd5, 3'd2));
      step();
      rd_req = 1'b0;
      repeat (3) step();

      // Reader holds the port for 4 cycles while the host waits
      rx[0] = 8'd5;   rp[0] = 3'd2;
      rx[1] = 8'd0;   rp[1] = 3'd0;
      rx[2] = 8'd1;   rp[2] = 3'd3;
      rx[3] = 8'd250; rp[3] = 3'd1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               rd_push(rx[i], rp[i], exp_rd(rx[i], rp[i]));
               step();
            end
            rd_req = 1'b0;
         end
         begin
            host_write(8'd3, 3'd1, 8'h5A, waits, we, addr, wd);
         end
      join
      check("t2_wr_waits", waits, 4);
      check("t2_mem_we", we, 1);
      check("t2_mem_addr", addr, 25);
      check("t2_mem_wdata", wd, 8'h5A);
      shadow[25] = 8'h5A;
      rd_push(8'd3, 3'd1, exp_rd(8'd3, 3'd1));
      step();
      rd_req = 1'b0;
      repeat (3) step();

      // Full fill with 0xFF, no reader; a restart pulse mid-fill is ignored
      run_fill(8'hFF, 1'b1, busy_n, done_n, wr_n, bad_n);
      check("t3_busy_cycles", busy_n, FB);
      check("t3_done_pulses", done_n, 1);
      check("t3_writes", wr_n, FB);
      check("t3_bad", bad_n, 0);
      rd_push(8'd239, 3'd7, exp_rd(8'd239, 3'd7));
      step();
      rd_push(8'd0, 3'd0, exp_rd(8'd0, 3'd0));
      step();
      rd_req = 1'b0;
      repeat (3) step();

      // Fill 0x3C with a reader every 4th cycle
      clear_start = 1'b1;
      clear_value = 8'h3C;
      step();
      clear_start = 1'b0;
      cnt_m = 0; nrd = 0; busy_n = 0; done_n = 0;
      for (int k = 0; k < 2700; k++) begin
         if (k % 4 == 3) begin
            x  = 8'($urandom_range(0, 249));
            pg = 3'($urandom_range(0, 7));
            a  = int'(x) * 8 + int'(pg);
            if (x >= 8'd240)  e = 8'h00;
            else if (a < cnt_m) e = 8'h3C;
            else              e = shadow[a];
            rd_push(x, pg, e);
            if (cnt_m < FB) nrd++;
         end else begin
            rd_req = 1'b0;
            if (cnt_m < FB) cnt_m++;
         end
         #3;
         if (busy) busy_n++;
         if (clear_done) done_n++;
         step();
      end
      rd_req = 1'b0;
      for (int i = 0; i < FB; i++) shadow[i] = 8'h3C;
      repeat (3) step();
      check("t4_busy_cycles", busy_n, FB + nrd);
      check("t4_done_pulses", done_n, 1);

      // Out-of-range host writes and error counter saturation
      host_write(8'd240, 3'd0, 8'h11, waits, we, addr, wd);
      check("t5_oor_we", we, 0);
      check("t5_err_1", err_count, 1);
      host_write(8'd0, 3'd7, 8'h22, waits, we, addr, wd);
      check("t5_inr_we", we, 1);
      check("t5_inr_addr", addr, 7);
      check("t5_err_still_1", err_count, 1);
      shadow[7] = 8'h22;
      for (int i = 0; i < 300; i++) host_write(8'd250, 3'd0, 8'h33, waits, we, addr, wd);
      check("t5_err_sat", err_count, 255);
      rd_push(8'd0, 3'd7, exp_rd(8'd0, 3'd7));
      step();
      rd_push(8'd240, 3'd0, exp_rd(8'd240, 3'd0));
      step();
      rd_req = 1'b0;
      repeat (3) step();

      // Reset mid-fill aborts silently; a fresh fill starts over from address 0
      clear_start = 1'b1;
      clear_value = 8'h77;
      step();
      clear_start = 1'b0;
      repeat (1000) step();
      reset = 1'b0;
      #1;
      check("t6_busy_async", busy, 0);
      check("t6_we_in_reset", mem_we, 0);
      check("t6_err_reset", err_count, 0);
      done_n = 0;
      repeat (3) begin
         #2;
         if (clear_done || busy) done_n++;
         step();
      end
      reset = 1'b1;
      repeat (4) begin
         #3;
         if (clear_done || busy) done_n++;
         step();
      end
      check("t6_no_done", done_n, 0);
      run_fill(8'h00, 1'b0, busy_n, done_n, wr_n, bad_n);
      check("t6_busy_cycles", busy_n, FB);
      check("t6_done_pulses", done_n, 1);
      check("t6_writes", wr_n, FB);
      check("t6_bad", bad_n, 0);
      rd_push(8'd120, 3'd4, exp_rd(8'd120, 3'd4));
      step();
      rd_req = 1'b0;
      repeat (4) step();

      check("rd_drain", rq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
